// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response codes and bridge FSM state types
package axi4_lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Unprivileged, secure, data access for every request this bridge issues.
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

endpackage

// File: rtl/axi4_lite_if.sv
// rtl/axi4_lite_if.sv - AXI4-Lite bundle with master and slave views
interface axi4_lite_if #(
    parameter int ALEN = 32,
    parameter int DLEN = 32
);
    localparam int SLEN = DLEN / 8;

    logic [ALEN-1:0] awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DLEN-1:0] wdata;
    logic [SLEN-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [ALEN-1:0] araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DLEN-1:0] rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport M (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport S (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axi4_lite_m_rd.sv
// rtl/axi4_lite_m_rd.sv - read request FSM driving the AXI4-Lite AR and R channels
module axi4_lite_m_rd
    import axi4_lite_pkg::*;
#(
    parameter int MEM_ALEN = 16,
    parameter int DLEN     = 32,
    parameter int AXI_ALEN = 32,
    parameter int ALIGN    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_rvalid,
    output logic                req_rready,
    input  logic [MEM_ALEN-1:0] req_raddr,
    output logic                rsp_rvalid,
    output logic [DLEN-1:0]     rsp_rdata,
    output logic [1:0]          rsp_rresp,
    output logic [AXI_ALEN-1:0] araddr,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DLEN-1:0]     rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready
);

    rd_state_e           r_state;
    rd_state_e           r_state_nxt;
    logic [AXI_ALEN-1:0] araddr_q;
    logic [DLEN-1:0]     rdata_q;
    logic [1:0]          rresp_q;
    logic                rsp_rvalid_q;
    logic                r_accept;
    logic                r_done;

    assign r_accept = req_rvalid && req_rready;
    assign r_done   = (r_state == R_DATA) && rvalid;

    // State register plus the address latch and captured read response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= R_IDLE;
            araddr_q     <= '0;
            rdata_q      <= '0;
            rresp_q      <= OKAY;
            rsp_rvalid_q <= 1'b0;
        end else begin
            r_state      <= r_state_nxt;
            rsp_rvalid_q <= r_done;
            if (r_accept) begin
                araddr_q <= AXI_ALEN'(req_raddr) << ALIGN;
            end
            if (r_done) begin
                rdata_q <= rdata;
                rresp_q <= rresp;
            end
        end
    end

    // Next state: arvalid lives exactly as long as R_ADDR, so the AR handshake ends it.
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (r_accept) r_state_nxt = R_ADDR;
            R_ADDR:  if (arready)  r_state_nxt = R_DATA;
            R_DATA:  if (rvalid)   r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Outputs decoded from state; the request port is held off while in reset.
    always_comb begin
        req_rready = (r_state == R_IDLE) && !rst;
        arvalid    = (r_state == R_ADDR);
        rready     = (r_state == R_DATA);
        araddr     = araddr_q;
        arprot     = PROT_DEFAULT;
        rsp_rvalid = rsp_rvalid_q;
        rsp_rdata  = rdata_q;
        rsp_rresp  = rresp_q;
    end

endmodule

// File: rtl/mem_2_axi4_lite.sv
// rtl/mem_2_axi4_lite.sv - memory-style request port to AXI4-Lite master bridge
module mem_2_axi4_lite
    import axi4_lite_pkg::*;
#(
    parameter int MEM_ALEN = 16,
    parameter int DLEN     = 32,
    parameter int SLEN     = DLEN / 8
) (
    input  logic                clk,
    input  logic                rst,
    axi4_lite_if.M              axi,
    input  logic                req_wvalid,
    output logic                req_wready,
    input  logic [MEM_ALEN-1:0] req_waddr,
    input  logic [DLEN-1:0]     req_wdata,
    input  logic [SLEN-1:0]     req_wstrb,
    output logic                rsp_wvalid,
    output logic [1:0]          rsp_wresp,
    input  logic                req_rvalid,
    output logic                req_rready,
    input  logic [MEM_ALEN-1:0] req_raddr,
    output logic                rsp_rvalid,
    output logic [DLEN-1:0]     rsp_rdata,
    output logic [1:0]          rsp_rresp
);

    localparam int ALIGN    = $clog2(SLEN);
    localparam int AXI_ALEN = $bits(axi.awaddr);

    if (AXI_ALEN < MEM_ALEN + ALIGN) begin : g_bad_alen
        $error("axi address bus too narrow for MEM_ALEN word addresses");
    end
    if ($bits(axi.wdata) != DLEN) begin : g_bad_dlen
        $error("axi data width differs from DLEN");
    end

    wr_state_e           w_state;
    wr_state_e           w_state_nxt;
    logic                aw_pend;
    logic                aw_pend_nxt;
    logic                w_pend;
    logic                w_pend_nxt;
    logic [AXI_ALEN-1:0] awaddr_q;
    logic [DLEN-1:0]     wdata_q;
    logic [SLEN-1:0]     wstrb_q;
    logic [1:0]          wresp_q;
    logic                rsp_wvalid_q;
    logic                w_accept;
    logic                w_done;

    assign w_accept = req_wvalid && req_wready;
    assign w_done   = (w_state == W_RESP) && axi.bvalid;

    // State register, per-channel pending flags, payload latch and captured bresp.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state      <= W_IDLE;
            aw_pend      <= 1'b0;
            w_pend       <= 1'b0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wresp_q      <= OKAY;
            rsp_wvalid_q <= 1'b0;
        end else begin
            w_state      <= w_state_nxt;
            aw_pend      <= aw_pend_nxt;
            w_pend       <= w_pend_nxt;
            rsp_wvalid_q <= w_done;
            if (w_accept) begin
                awaddr_q <= AXI_ALEN'(req_waddr) << ALIGN;
                wdata_q  <= req_wdata;
                wstrb_q  <= req_wstrb;
            end
            if (w_done) begin
                wresp_q <= axi.bresp;
            end
        end
    end

    // Next state: AW and W retire independently; W_RESP is entered once neither is pending.
    always_comb begin
        w_state_nxt = w_state;
        aw_pend_nxt = aw_pend;
        w_pend_nxt  = w_pend;
        case (w_state)
            W_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = W_ADDR;
                    aw_pend_nxt = 1'b1;
                    w_pend_nxt  = 1'b1;
                end
            end
            W_ADDR: begin
                if (aw_pend && axi.awready) aw_pend_nxt = 1'b0;
                if (w_pend && axi.wready)   w_pend_nxt  = 1'b0;
                if (!aw_pend_nxt && !w_pend_nxt) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                if (axi.bvalid) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write-side outputs; valids come straight from the pending flags.
    always_comb begin
        req_wready = (w_state == W_IDLE) && !rst;
        axi.awvalid = aw_pend;
        axi.awaddr  = awaddr_q;
        axi.awprot  = PROT_DEFAULT;
        axi.wvalid  = w_pend;
        axi.wdata   = wdata_q;
        axi.wstrb   = wstrb_q;
        axi.bready  = (w_state == W_RESP);
        rsp_wvalid  = rsp_wvalid_q;
        rsp_wresp   = wresp_q;
    end

    axi4_lite_m_rd #(
        .MEM_ALEN (MEM_ALEN),
        .DLEN     (DLEN),
        .AXI_ALEN (AXI_ALEN),
        .ALIGN    (ALIGN)
    ) u_rd (
        .clk        (clk),
        .rst        (rst),
        .req_rvalid (req_rvalid),
        .req_rready (req_rready),
        .req_raddr  (req_raddr),
        .rsp_rvalid (rsp_rvalid),
        .rsp_rdata  (rsp_rdata),
        .rsp_rresp  (rsp_rresp),
        .araddr     (axi.araddr),
        .arprot     (axi.arprot),
        .arvalid    (axi.arvalid),
        .arready    (axi.arready),
        .rdata      (axi.rdata),
        .rresp      (axi.rresp),
        .rvalid     (axi.rvalid),
        .rready     (axi.rready)
    );

endmodule

// File: tb/tb_mem_2_axi4_lite.sv
// tb/tb_mem_2_axi4_lite.sv - directed self-checking bench for mem_2_axi4_lite
module tb_mem_2_axi4_lite;
    import axi4_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_wvalid = 1'b0;
    logic        req_wready;
    logic [15:0] req_waddr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_wvalid;
    logic [1:0]  rsp_wresp;
    logic        req_rvalid = 1'b0;
    logic        req_rready;
    logic [15:0] req_raddr = '0;
    logic        rsp_rvalid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_rresp;

    int checks = 0;
    int errors = 0;
    int wpulses = 0;
    int rpulses = 0;

    axi4_lite_if #(.ALEN(32), .DLEN(32)) axi_bus ();

    mem_2_axi4_lite #(.MEM_ALEN(16), .DLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .axi        (axi_bus.M),
        .req_wvalid (req_wvalid),
        .req_wready (req_wready),
        .req_waddr  (req_waddr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .rsp_wvalid (rsp_wvalid),
        .rsp_wresp  (rsp_wresp),
        .req_rvalid (req_rvalid),
        .req_rready (req_rready),
        .req_raddr  (req_raddr),
        .rsp_rvalid (rsp_rvalid),
        .rsp_rdata  (rsp_rdata),
        .rsp_rresp  (rsp_rresp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Protocol watch: valids and payloads must hold until their handshake; no early responses.
    logic        aw_hold = 1'b0, w_hold = 1'b0, ar_hold = 1'b0;
    logic [31:0] aw_prev = '0, w_prev = '0, ar_prev = '0;
    always @(posedge clk) begin
        if (!rst) begin
            if (aw_hold) begin
                chk("mon_awvalid_hold", {31'd0, axi_bus.awvalid}, 32'd1);
                chk("mon_awaddr_stable", axi_bus.awaddr, aw_prev);
            end
            if (w_hold) begin
                chk("mon_wvalid_hold", {31'd0, axi_bus.wvalid}, 32'd1);
                chk("mon_wdata_stable", axi_bus.wdata, w_prev);
            end
            if (ar_hold) begin
                chk("mon_arvalid_hold", {31'd0, axi_bus.arvalid}, 32'd1);
                chk("mon_araddr_stable", axi_bus.araddr, ar_prev);
            end
            if (axi_bus.bvalid) chk("mon_bvalid_early", {31'd0, axi_bus.bready}, 32'd1);
            if (axi_bus.rvalid) chk("mon_rvalid_early", {31'd0, axi_bus.rready}, 32'd1);
            if (rsp_wvalid) wpulses++;
            if (rsp_rvalid) rpulses++;
        end
        aw_hold = !rst && axi_bus.awvalid && !axi_bus.awready;
        w_hold  = !rst && axi_bus.wvalid && !axi_bus.wready;
        ar_hold = !rst && axi_bus.arvalid && !axi_bus.arready;
        aw_prev = axi_bus.awaddr;
        w_prev  = axi_bus.wdata;
        ar_prev = axi_bus.araddr;
    end

    initial begin
        int          stall;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;

        axi_bus.awready = 1'b0;
        axi_bus.wready  = 1'b0;
        axi_bus.bvalid  = 1'b0;
        axi_bus.bresp   = OKAY;
        axi_bus.arready = 1'b0;
        axi_bus.rvalid  = 1'b0;
        axi_bus.rdata   = '0;
        axi_bus.rresp   = OKAY;

        // Reset state
        tick(); tick(); tick();
        chk("rst_req_wready", {31'd0, req_wready}, 32'd0);
        chk("rst_req_rready", {31'd0, req_rready}, 32'd0);
        chk("rst_awvalid", {31'd0, axi_bus.awvalid}, 32'd0);
        chk("rst_wvalid", {31'd0, axi_bus.wvalid}, 32'd0);
        chk("rst_arvalid", {31'd0, axi_bus.arvalid}, 32'd0);
        chk("rst_bready", {31'd0, axi_bus.bready}, 32'd0);
        chk("rst_rready", {31'd0, axi_bus.rready}, 32'd0);
        chk("rst_rsp_wvalid", {31'd0, rsp_wvalid}, 32'd0);
        chk("rst_rsp_rvalid", {31'd0, rsp_rvalid}, 32'd0);
        chk("rst_rsp_wresp", {30'd0, rsp_wresp}, 32'd0);
        chk("rst_rsp_rresp", {30'd0, rsp_rresp}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_req_wready", {31'd0, req_wready}, 32'd1);
        chk("idle_req_rready", {31'd0, req_rready}, 32'd1);

        // Single write, zero-wait slave
        axi_bus.awready = 1'b1; axi_bus.wready = 1'b1;
        req_wvalid = 1'b1; req_waddr = 16'h0010; req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
        tick();
        req_wvalid = 1'b0;
        chk("w1_awvalid", {31'd0, axi_bus.awvalid}, 32'd1);
        chk("w1_wvalid", {31'd0, axi_bus.wvalid}, 32'd1);
        chk("w1_awaddr", axi_bus.awaddr, 32'h0000_0040);
        chk("w1_awprot", {29'd0, axi_bus.awprot}, 32'd0);
        chk("w1_wdata", axi_bus.wdata, 32'hDEADBEEF);
        chk("w1_wstrb", {28'd0, axi_bus.wstrb}, 32'hF);
        chk("w1_req_wready_busy", {31'd0, req_wready}, 32'd0);
        chk("w1_bready_c1", {31'd0, axi_bus.bready}, 32'd0);
        tick();
        chk("w1_awvalid_c2", {31'd0, axi_bus.awvalid}, 32'd0);
        chk("w1_wvalid_c2", {31'd0, axi_bus.wvalid}, 32'd0);
        chk("w1_bready_c2", {31'd0, axi_bus.bready}, 32'd1);
        chk("w1_rsp_c2", {31'd0, rsp_wvalid}, 32'd0);
        axi_bus.bvalid = 1'b1; axi_bus.bresp = OKAY;
        tick();
        axi_bus.bvalid = 1'b0; axi_bus.awready = 1'b0; axi_bus.wready = 1'b0;
        chk("w1_rsp_c3", {31'd0, rsp_wvalid}, 32'd1);
        chk("w1_rsp_wresp", {30'd0, rsp_wresp}, 32'd0);
        chk("w1_req_wready_c3", {31'd0, req_wready}, 32'd1);
        chk("w1_bready_c3", {31'd0, axi_bus.bready}, 32'd0);
        tick();
        chk("w1_rsp_c4", {31'd0, rsp_wvalid}, 32'd0);

        // AW first, W delayed to cycle 5
        req_wvalid = 1'b1; req_waddr = 16'h0020; req_wdata = 32'h11112222; req_wstrb = 4'h3;
        tick();
        req_wvalid = 1'b0;
        chk("w2_awvalid_c1", {31'd0, axi_bus.awvalid}, 32'd1);
        chk("w2_wvalid_c1", {31'd0, axi_bus.wvalid}, 32'd1);
        axi_bus.awready = 1'b1;
        tick();
        axi_bus.awready = 1'b0;
        chk("w2_awvalid_c2", {31'd0, axi_bus.awvalid}, 32'd0);
        chk("w2_wvalid_c2", {31'd0, axi_bus.wvalid}, 32'd1);
        chk("w2_bready_c2", {31'd0, axi_bus.bready}, 32'd0);
        tick();
        chk("w2_wvalid_c3", {31'd0, axi_bus.wvalid}, 32'd1);
        tick();
        chk("w2_wvalid_c4", {31'd0, axi_bus.wvalid}, 32'd1);
        tick();
        chk("w2_wvalid_c5", {31'd0, axi_bus.wvalid}, 32'd1);
        chk("w2_wdata_c5", axi_bus.wdata, 32'h11112222);
        chk("w2_wstrb_c5", {28'd0, axi_bus.wstrb}, 32'h3);
        chk("w2_bready_c5", {31'd0, axi_bus.bready}, 32'd0);
        axi_bus.wready = 1'b1;
        tick();
        axi_bus.wready = 1'b0;
        chk("w2_wvalid_c6", {31'd0, axi_bus.wvalid}, 32'd0);
        chk("w2_bready_c6", {31'd0, axi_bus.bready}, 32'd1);
        axi_bus.bvalid = 1'b1; axi_bus.bresp = OKAY;
        tick();
        axi_bus.bvalid = 1'b0;
        chk("w2_rsp_c7", {31'd0, rsp_wvalid}, 32'd1);
        tick();
        chk("w2_rsp_c8", {31'd0, rsp_wvalid}, 32'd0);

        // W first, AW later, SLVERR response, then an immediate follow-up write
        req_wvalid = 1'b1; req_waddr = 16'h0030; req_wdata = 32'hA5A5A5A5; req_wstrb = 4'hC;
        tick();
        req_wvalid = 1'b0;
        axi_bus.wready = 1'b1;
        tick();
        axi_bus.wready = 1'b0;
        chk("w3_wvalid_c2", {31'd0, axi_bus.wvalid}, 32'd0);
        chk("w3_awvalid_c2", {31'd0, axi_bus.awvalid}, 32'd1);
        chk("w3_bready_c2", {31'd0, axi_bus.bready}, 32'd0);
        tick();
        chk("w3_awaddr_c3", axi_bus.awaddr, 32'h0000_00C0);
        axi_bus.awready = 1'b1;
        tick();
        axi_bus.awready = 1'b0;
        chk("w3_awvalid_c4", {31'd0, axi_bus.awvalid}, 32'd0);
        chk("w3_bready_c4", {31'd0, axi_bus.bready}, 32'd1);
        axi_bus.bvalid = 1'b1; axi_bus.bresp = SLVERR;
        tick();
        axi_bus.bvalid = 1'b0; axi_bus.bresp = OKAY;
        chk("w3_rsp_c5", {31'd0, rsp_wvalid}, 32'd1);
        chk("w3_rsp_slverr", {30'd0, rsp_wresp}, 32'd2);
        chk("w3_req_wready_c5", {31'd0, req_wready}, 32'd1);
        req_wvalid = 1'b1; req_waddr = 16'h0001; req_wdata = 32'h0000_00FF; req_wstrb = 4'h1;
        axi_bus.awready = 1'b1; axi_bus.wready = 1'b1;
        tick();
        req_wvalid = 1'b0;
        chk("w3b_awvalid", {31'd0, axi_bus.awvalid}, 32'd1);
        chk("w3b_awaddr", axi_bus.awaddr, 32'h0000_0004);
        chk("w3b_req_wready", {31'd0, req_wready}, 32'd0);
        chk("w3b_wresp_held", {30'd0, rsp_wresp}, 32'd2);
        chk("w3b_rsp_c6", {31'd0, rsp_wvalid}, 32'd0);
        tick();
        chk("w3b_bready", {31'd0, axi_bus.bready}, 32'd1);
        axi_bus.bvalid = 1'b1; axi_bus.bresp = OKAY;
        tick();
        axi_bus.bvalid = 1'b0; axi_bus.awready = 1'b0; axi_bus.wready = 1'b0;
        chk("w3b_rsp", {31'd0, rsp_wvalid}, 32'd1);
        chk("w3b_wresp_okay", {30'd0, rsp_wresp}, 32'd0);
        tick();

        // Concurrent write and read accepted in the same cycle
        axi_bus.awready = 1'b1; axi_bus.wready = 1'b1; axi_bus.arready = 1'b1;
        req_wvalid = 1'b1; req_waddr = 16'h0004; req_wdata = 32'h12345678; req_wstrb = 4'hF;
        req_rvalid = 1'b1; req_raddr = 16'h0004;
        tick();
        req_wvalid = 1'b0; req_rvalid = 1'b0;
        chk("c_awvalid", {31'd0, axi_bus.awvalid}, 32'd1);
        chk("c_arvalid", {31'd0, axi_bus.arvalid}, 32'd1);
        chk("c_awaddr", axi_bus.awaddr, 32'h0000_0010);
        chk("c_araddr", axi_bus.araddr, 32'h0000_0010);
        chk("c_arprot", {29'd0, axi_bus.arprot}, 32'd0);
        chk("c_wdata", axi_bus.wdata, 32'h12345678);
        chk("c_req_rready", {31'd0, req_rready}, 32'd0);
        tick();
        axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.arready = 1'b0;
        chk("c_bready", {31'd0, axi_bus.bready}, 32'd1);
        chk("c_rready", {31'd0, axi_bus.rready}, 32'd1);
        chk("c_arvalid_c2", {31'd0, axi_bus.arvalid}, 32'd0);
        axi_bus.bvalid = 1'b1; axi_bus.bresp = OKAY;
        axi_bus.rvalid = 1'b1; axi_bus.rdata = 32'hCAFEF00D; axi_bus.rresp = OKAY;
        tick();
        axi_bus.bvalid = 1'b0; axi_bus.rvalid = 1'b0;
        chk("c_rsp_wvalid", {31'd0, rsp_wvalid}, 32'd1);
        chk("c_rsp_rvalid", {31'd0, rsp_rvalid}, 32'd1);
        chk("c_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
        chk("c_rsp_rresp", {30'd0, rsp_rresp}, 32'd0);
        chk("c_req_rready_c3", {31'd0, req_rready}, 32'd1);
        tick();

        // Eight back-to-back reads with random AR and R stalls
        for (int i = 0; i < 8; i++) begin
            exp_data = 32'h1000_0000 + 32'(i) * 32'h0000_0111;
            exp_resp = (i == 3) ? EXOKAY : ((i == 5) ? DECERR : OKAY);
            chk("b_req_rready_idle", {31'd0, req_rready}, 32'd1);
            req_rvalid = 1'b1; req_raddr = 16'h0100 + 16'(i);
            tick();
            req_rvalid = 1'b0;
            chk("b_arvalid", {31'd0, axi_bus.arvalid}, 32'd1);
            chk("b_araddr", axi_bus.araddr, 32'((32'h100 + 32'(i)) * 4));
            stall = int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                tick();
                chk("b_arvalid_stall", {31'd0, axi_bus.arvalid}, 32'd1);
                chk("b_req_rready_ar", {31'd0, req_rready}, 32'd0);
            end
            axi_bus.arready = 1'b1;
            tick();
            axi_bus.arready = 1'b0;
            chk("b_arvalid_done", {31'd0, axi_bus.arvalid}, 32'd0);
            chk("b_rready", {31'd0, axi_bus.rready}, 32'd1);
            stall = int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                tick();
                chk("b_rready_stall", {31'd0, axi_bus.rready}, 32'd1);
                chk("b_req_rready_r", {31'd0, req_rready}, 32'd0);
                chk("b_rsp_quiet", {31'd0, rsp_rvalid}, 32'd0);
            end
            axi_bus.rvalid = 1'b1; axi_bus.rdata = exp_data; axi_bus.rresp = exp_resp;
            tick();
            axi_bus.rvalid = 1'b0;
            chk("b_rsp_rvalid", {31'd0, rsp_rvalid}, 32'd1);
            chk("b_rsp_rdata", rsp_rdata, exp_data);
            chk("b_rsp_rresp", {30'd0, rsp_rresp}, {30'd0, exp_resp});
        end
        tick();
        chk("b_rsp_rvalid_end", {31'd0, rsp_rvalid}, 32'd0);

        // Reset while the write sits in W_ADDR (read also in flight)
        req_wvalid = 1'b1; req_waddr = 16'h0050; req_wdata = 32'h5555AAAA; req_wstrb = 4'hF;
        req_rvalid = 1'b1; req_raddr = 16'h0060;
        tick();
        req_wvalid = 1'b0; req_rvalid = 1'b0;
        chk("r_awvalid_c1", {31'd0, axi_bus.awvalid}, 32'd1);
        tick();
        chk("r_awvalid_c2", {31'd0, axi_bus.awvalid}, 32'd1);
        chk("r_wvalid_c2", {31'd0, axi_bus.wvalid}, 32'd1);
        rst = 1'b1;
        tick();
        chk("r_awvalid", {31'd0, axi_bus.awvalid}, 32'd0);
        chk("r_wvalid", {31'd0, axi_bus.wvalid}, 32'd0);
        chk("r_arvalid", {31'd0, axi_bus.arvalid}, 32'd0);
        chk("r_bready", {31'd0, axi_bus.bready}, 32'd0);
        chk("r_rready", {31'd0, axi_bus.rready}, 32'd0);
        chk("r_req_wready_in_rst", {31'd0, req_wready}, 32'd0);
        chk("r_rsp_wvalid", {31'd0, rsp_wvalid}, 32'd0);
        rst = 1'b0;
        tick();
        chk("r_req_wready_after", {31'd0, req_wready}, 32'd1);
        chk("r_req_rready_after", {31'd0, req_rready}, 32'd1);
        chk("r_rsp_wvalid_after", {31'd0, rsp_wvalid}, 32'd0);
        tick(); tick();

        chk("total_write_pulses", 32'(wpulses), 32'd5);
        chk("total_read_pulses", 32'(rpulses), 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
